// File: rtl/voice_sched_pkg.sv
// -----------------------------------------------------------------------------
// voice_sched_pkg
// Shared types and helpers for the voice frame sequencer.
//   state_t        : sequencer FSM encoding
//   DEF_*          : default frame geometry
//   min_frame_len  : clocks from tick to return-to-IDLE with an always-ready
//                    output stage and no voices masked; divisor settings must
//                    leave at least this many clocks between ticks
// -----------------------------------------------------------------------------
package voice_sched_pkg;

    localparam int DEF_NUM_VOICES  = 3;
    localparam int DEF_SLOT_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VOICE = 2'd1,
        ST_MIX   = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // One slot per voice, plus one MIX clock and one OUT clock.
    function automatic int min_frame_len(input int num_voices, input int slot_cycles);
        return num_voices * slot_cycles + 2;
    endfunction

endpackage

// File: rtl/voice_sched_if.sv
// -----------------------------------------------------------------------------
// voice_sched_if
// Control/status bundle between the frame sequencer and its surroundings.
//   Inputs to the sequencer : tick_en, enable, sample_ready, clr_overrun,
//                             voice_mask (only with VOICE_SCHED_MASK_EN)
//   Outputs from sequencer  : voice_sel, voice_phase, voice_strobe, mix_strobe,
//                             sample_valid, busy, overrun
// Modports:
//   slave  : the sequencer itself
//   master : the side that drives ticks/handshake and observes the sequencer
// Optional feature macro: VOICE_SCHED_MASK_EN
// -----------------------------------------------------------------------------
interface voice_sched_if
    import voice_sched_pkg::*;
#(
    parameter int NUM_VOICES  = DEF_NUM_VOICES,
    parameter int SLOT_CYCLES = DEF_SLOT_CYCLES
) ();

    localparam int VSEL_W = (NUM_VOICES  > 1) ? $clog2(NUM_VOICES)  : 1;
    localparam int PH_W   = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    logic              tick_en;
    logic              enable;
    logic              sample_ready;
    logic              clr_overrun;
`ifdef VOICE_SCHED_MASK_EN
    logic [NUM_VOICES-1:0] voice_mask;
`endif
    logic [VSEL_W-1:0] voice_sel;
    logic [PH_W-1:0]   voice_phase;
    logic              voice_strobe;
    logic              mix_strobe;
    logic              sample_valid;
    logic              busy;
    logic              overrun;

    modport slave (
        input  tick_en,
        input  enable,
        input  sample_ready,
        input  clr_overrun,
`ifdef VOICE_SCHED_MASK_EN
        input  voice_mask,
`endif
        output voice_sel,
        output voice_phase,
        output voice_strobe,
        output mix_strobe,
        output sample_valid,
        output busy,
        output overrun
    );

    modport master (
        output tick_en,
        output enable,
        output sample_ready,
        output clr_overrun,
`ifdef VOICE_SCHED_MASK_EN
        output voice_mask,
`endif
        input  voice_sel,
        input  voice_phase,
        input  voice_strobe,
        input  mix_strobe,
        input  sample_valid,
        input  busy,
        input  overrun
    );

endinterface

// File: rtl/voice_sched.sv
// -----------------------------------------------------------------------------
// voice_sched
// Frame sequencer for the shared voice datapath. Each sample tick runs one
// frame: every voice gets SLOT_CYCLES clocks, then one mixer strobe, then a
// sample_valid/sample_ready handshake with the output stage. A tick arriving
// mid-frame is queued once (pending); a second one is dropped and flagged in
// the sticky overrun bit.
// Ports:
//   clk      : system clock
//   n_reset  : asynchronous active-low reset
//   bus      : voice_sched_if.slave (tick/enable/handshake in, sequencing out)
// Optional feature macro: VOICE_SCHED_MASK_EN adds a per-frame voice mask;
// masked voices take zero clocks.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a tick (or a pending tick) with enable high
// ST_VOICE | sequencing voice slots; phase counts 0..SLOT_CYCLES-1
// ST_MIX   | single-cycle mixer strobe
// ST_OUT   | sample_valid held until sample_ready
// -----------------------------------------------------------------------------
module voice_sched
    import voice_sched_pkg::*;
#(
    parameter int NUM_VOICES  = DEF_NUM_VOICES,
    parameter int SLOT_CYCLES = DEF_SLOT_CYCLES
) (
    input  logic         clk,
    input  logic         n_reset,
    voice_sched_if.slave bus
);

    localparam int VSEL_W = (NUM_VOICES  > 1) ? $clog2(NUM_VOICES)  : 1;
    localparam int PH_W   = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(SLOT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [VSEL_W-1:0] vsel_q, vsel_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              start;
    logic              ovr_set;

`ifdef VOICE_SCHED_MASK_EN
    logic [NUM_VOICES-1:0] mask_q, mask_d;
    logic [VSEL_W:0]       first_hit;
    logic [VSEL_W:0]       next_hit;

    // Lowest unmasked voice at or above 'from'; MSB flags that one exists.
    function automatic logic [VSEL_W:0] find_voice(input logic [NUM_VOICES-1:0] m,
                                                   input int from);
        logic [VSEL_W:0] r;
        r = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (i >= from && !m[i]) begin
                r = {1'b1, VSEL_W'(i)};
            end
        end
        return r;
    endfunction

    assign first_hit = find_voice(bus.voice_mask, 0);
    assign next_hit  = find_voice(mask_q, int'(vsel_q) + 1);
`else
    localparam logic [VSEL_W-1:0] LAST_VOICE = VSEL_W'(NUM_VOICES - 1);
`endif

    assign start   = bus.enable && (bus.tick_en || pending_q);
    // A tick while one is already queued is dropped and flagged.
    assign ovr_set = bus.enable && bus.tick_en && pending_q;

    always_comb begin
        state_d   = state_q;
        vsel_d    = vsel_q;
        phase_d   = phase_q;
        pending_d = pending_q;
`ifdef VOICE_SCHED_MASK_EN
        mask_d    = mask_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    phase_d = '0;
`ifdef VOICE_SCHED_MASK_EN
                    mask_d = bus.voice_mask;
                    if (first_hit[VSEL_W]) begin
                        state_d = ST_VOICE;
                        vsel_d  = first_hit[VSEL_W-1:0];
                    end else begin
                        state_d = ST_MIX;
                        vsel_d  = '0;
                    end
`else
                    state_d = ST_VOICE;
                    vsel_d  = '0;
`endif
                end
            end
            ST_VOICE: begin
                if (phase_q == LAST_PHASE) begin
                    phase_d = '0;
`ifdef VOICE_SCHED_MASK_EN
                    if (next_hit[VSEL_W]) begin
                        vsel_d = next_hit[VSEL_W-1:0];
                    end else begin
                        state_d = ST_MIX;
                    end
`else
                    if (vsel_q == LAST_VOICE) begin
                        state_d = ST_MIX;
                    end else begin
                        vsel_d = vsel_q + 1'b1;
                    end
`endif
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_MIX: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.sample_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pending bookkeeping: enable low flushes it; a start consumes it;
        // a first tick during a frame queues it.
        if (!bus.enable) begin
            pending_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (start) begin
                pending_d = 1'b0;
            end
        end else if (bus.tick_en && !pending_q) begin
            pending_d = 1'b1;
        end

        // Set beats a simultaneous clear.
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= ST_IDLE;
            vsel_q    <= '0;
            phase_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef VOICE_SCHED_MASK_EN
            mask_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            vsel_q    <= vsel_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
`ifdef VOICE_SCHED_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign bus.voice_sel    = vsel_q;
    assign bus.voice_phase  = phase_q;
    assign bus.voice_strobe = (state_q == ST_VOICE) && (phase_q == '0);
    assign bus.mix_strobe   = (state_q == ST_MIX);
    assign bus.sample_valid = (state_q == ST_OUT);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.overrun      = overrun_q;

endmodule
